fg_wave_gen: RTL and testbench
==============================

# fg_wave_gen

Phase-accumulator waveform generator for the DDS function generator. It runs on the divided `Fg_CLK` and produces one offset-binary DAC sample per cycle: sine, square, sawtooth or triangle. Samples go to the DAC output register stage, which is clocked on `Dac_CLK`. Frequency and waveform changes arrive through a valid/ready handshake and are applied glitch-free at the next phase wrap.

## Interface
- `PHASE_W`, default 32: accumulator and tuning word width.
- `DAC_W`, default 10: sample width, offset binary.
- `LUT_AW`, default 8: quarter-wave sine LUT address width, 2^LUT_AW entries.
- `Fg_CLK`  in  1  generator clock. The block uses this single clock only.
- `Fg_RESET`  in  1  asynchronous, active-high reset.
- `Run_En`  in  1  level: 1 = generate, 0 = stop and park at mid-scale.
- `Cfg_Valid`  in  1  config offer.
- `Cfg_Ready`  out  1  config accept.
- `Cfg_Ftw`  in  PHASE_W  frequency tuning word.
- `Cfg_Wave`  in  2  waveform select: 0 sine, 1 square, 2 saw, 3 triangle.
- `Dac_Data`  out  DAC_W  sample.
- `Dac_Valid`  out  1  sample is live waveform data.
- `Phase_Wrap`  out  1  one-cycle pulse per period.

## Operation
- Reset values:
  - `Dac_Data` = 2^(DAC_W-1) (0x200), `Dac_Valid` = 0, `Phase_Wrap` = 0, `Cfg_Ready` = 1.
  - Phase = 0, active FTW = 0, active wave = sine, state IDLE.
- States:
  - IDLE: phase held at 0, output parked mid-scale.
  - RUN: accumulating.
  - PEND: a config has been accepted and waits for a wrap.
- Transfer: a config transfers when `Cfg_Valid & Cfg_Ready` at a rising edge. `Cfg_Ready` = 1 in IDLE and RUN, 0 in PEND.
- In IDLE, an accepted config loads the active FTW and wave directly. Transition IDLE→RUN when `Run_En` = 1.
- In RUN, an accepted config is captured into pending registers and the state goes to PEND.
- In PEND, pending → active on the cycle the accumulator carries out, with phase continuity: phase keeps its residue. The state then returns to RUN.
  - If the active FTW = 0, pending applies on the next cycle.
- `Run_En` = 0 in RUN or PEND goes to IDLE next cycle.
  - Phase clears to 0.
  - A pending config is applied immediately.
  - `Run_En` falling together with `Cfg_Valid` is a stop; the new config goes straight to active.
- Phase arithmetic: phase <= phase + FTW mod 2^PHASE_W. The carry-out marks the wrap.
- Sample mapping uses p = phase[PHASE_W-1 -: DAC_W+?] fields; M = 2^(DAC_W-1).
  - Saw: phase[PHASE_W-1 -: DAC_W].
  - Square: all ones if phase MSB = 0, else 0.
  - Triangle: phase[PHASE_W-2 -: DAC_W] when MSB = 0, else its bitwise inverse.
  - Sine:
    - The quadrant is the top 2 bits. The address is the next LUT_AW bits, bit-inverted in quadrants 1 and 3.
    - Quadrants 0/1 give M + lut. Quadrants 2/3 give M - lut.
    - lut[i] = round((M-1)·sin((i+0.5)·π/2^(LUT_AW+1))). Its maximum is 511, so the range is 0x001..0x3FF.

## Timing
- Pipeline:
  - Stage 0: phase register.
  - Stage 1: registered LUT read plus shape select.
  - Stage 2: `Dac_Data` register.
- Phase at cycle n appears on `Dac_Data` at n+2.
- First RUN cycle has phase = 0. `Dac_Valid` rises 2 cycles later and falls 1 cycle after leaving RUN/PEND for IDLE, when `Dac_Data` returns to mid-scale.
- `Phase_Wrap` is registered. It pulses the cycle after the carry, aligned to the stage-0 phase.
- Wave select changes take effect with the FTW change, on the same sample.
- An asynchronous `Fg_RESET` mid-operation forces all reset values immediately. A pending config is discarded.

## Structure
- Shared package `fg_pkg` holds:
  - Wave select encoding: `WAVE_SINE`, `WAVE_SQUARE`, `WAVE_SAW`, `WAVE_TRI`.
  - The state enumeration.
  - The mid-scale constant function.
- Sub-module `fg_sine_lut` contains the quarter-wave ROM with registered output. It is parameterised by LUT_AW and DAC_W, and its contents are generated from the formula above.
- The top level holds the FSM, the accumulator, the pending registers and the output pipeline.

## Test plan
All scenarios use PHASE_W = 32, DAC_W = 10, LUT_AW = 8.
- Reset released → `Dac_Data` = 0x200, `Dac_Valid` = 0, `Cfg_Ready` = 1, `Phase_Wrap` = 0.
- Saw, FTW 0x0100_0000, `Run_En` = 1 → `Dac_Valid` rises 2 cycles after RUN. Samples step 0x000, 0x004, … 0x3FC, then 0x000. `Phase_Wrap` repeats every 256 cycles.
- Square, FTW 0x4000_0000 → 0x3FF, 0x3FF, 0x000, 0x000 repeating.
- Sine, FTW 0x4000_0000 → 0x202, 0x3FF, 0x1FE, 0x001 repeating.
- Saw running at FTW 0x0100_0000; offer FTW 0x0200_0000 mid-period:
  - `Cfg_Ready` drops the next cycle. A second offer is held off.
  - The slope doubles to a step of 8, starting exactly with the phase after the next `Phase_Wrap`.
  - `Cfg_Ready` returns to 1.
- `Run_En` dropped mid-run → `Dac_Data` = 0x200 and `Dac_Valid` = 0 one cycle later. `Fg_RESET` pulsed during PEND → outputs reset immediately, and after re-run the old active FTW is gone (FTW = 0).

Source files
------------

// File: rtl/fg_pkg.sv
// Shared definitions for the DDS function generator: wave select encoding,
// generator state enumeration and the DAC mid-scale helper.
package fg_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  function automatic int unsigned fg_mid_scale(input int unsigned dac_w);
    return 32'd1 << (dac_w - 1);
  endfunction

endpackage

// File: rtl/fg_sine_lut.sv
// Quarter-wave sine ROM with registered output; entries are
// round((M-1)*sin((i+0.5)*pi/2^(LUT_AW+1))) with M = 2^(DAC_W-1).
module fg_sine_lut #(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned DAC_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [DAC_W-2:0]  o_data
);

  localparam int unsigned DEPTH = 2 ** LUT_AW;
  localparam real PI = 3.14159265358979323846;

  function automatic logic [DAC_W-2:0] lut_entry(input int unsigned idx);
    real ang;
    real amp;
    ang = (real'(idx) + 0.5) * PI / real'(2 ** (LUT_AW + 1));
    amp = real'((2 ** (DAC_W - 1)) - 1) * $sin(ang);
    return (DAC_W-1)'($rtoi(amp + 0.5));
  endfunction

  logic [DAC_W-2:0] w_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = lut_entry(g);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
    end else begin
      o_data <= w_rom[i_addr];
    end
  end

endmodule

// File: rtl/fg_wave_gen.sv
// Phase-accumulator waveform generator: config handshake FSM, accumulator,
// pending config registers and a 3-stage phase-to-sample pipeline.
module fg_wave_gen
  import fg_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DAC_W   = 10,
  parameter int unsigned LUT_AW  = 8
) (
  input  logic               Fg_CLK,
  input  logic               Fg_RESET,
  input  logic               Run_En,
  input  logic               Cfg_Valid,
  output logic               Cfg_Ready,
  input  logic [PHASE_W-1:0] Cfg_Ftw,
  input  logic [1:0]         Cfg_Wave,
  output logic [DAC_W-1:0]   Dac_Data,
  output logic               Dac_Valid,
  output logic               Phase_Wrap
);

  localparam logic [DAC_W-1:0] MID = DAC_W'(fg_mid_scale(DAC_W));

  state_e             r_state, w_state_nx;
  logic [PHASE_W-1:0] r_phase, r_ftw, r_pend_ftw;
  wave_e              r_wave, r_pend_wave, r_wave1;
  logic [PHASE_W:0]   w_sum;
  logic               w_carry;
  logic               w_xfer, w_load_cfg, w_load_pend_act, w_load_pend;
  logic               w_phase_clr, w_accum;
  logic               r_live1, r_neg1, w_out_live;
  logic [DAC_W-1:0]   w_shape, r_shape1;
  logic [DAC_W-2:0]   w_lut;
  logic [LUT_AW-1:0]  w_addr;

  assign w_sum   = {1'b0, r_phase} + {1'b0, r_ftw};
  assign w_carry = w_sum[PHASE_W];

  always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
    if (Fg_RESET) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx      = r_state;
    Cfg_Ready       = (r_state != ST_PEND);
    w_load_cfg      = 1'b0;
    w_load_pend_act = 1'b0;
    w_load_pend     = 1'b0;
    w_phase_clr     = 1'b0;
    w_accum         = 1'b0;
    w_xfer          = Cfg_Valid & Cfg_Ready;
    case (r_state)
      ST_IDLE: begin
        w_phase_clr = 1'b1;
        w_load_cfg  = w_xfer;
        if (Run_En) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!Run_En) begin
          // A config arriving with the stop goes straight to active.
          w_state_nx  = ST_IDLE;
          w_phase_clr = 1'b1;
          w_load_cfg  = w_xfer;
        end else begin
          w_accum = 1'b1;
          if (w_xfer) begin
            w_load_pend = 1'b1;
            w_state_nx  = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!Run_En) begin
          w_state_nx      = ST_IDLE;
          w_phase_clr     = 1'b1;
          w_load_pend_act = 1'b1;
        end else begin
          w_accum = 1'b1;
          // Swap on the carry edge so the wrapped residue is kept; a zero FTW never carries.
          if (w_carry || (r_ftw == '0)) begin
            w_load_pend_act = 1'b1;
            w_state_nx      = ST_RUN;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
    if (Fg_RESET) begin
      r_phase     <= '0;
      r_ftw       <= '0;
      r_wave      <= WAVE_SINE;
      r_pend_ftw  <= '0;
      r_pend_wave <= WAVE_SINE;
      Phase_Wrap  <= 1'b0;
    end else begin
      if (w_phase_clr)  r_phase <= '0;
      else if (w_accum) r_phase <= w_sum[PHASE_W-1:0];
      if (w_load_cfg) begin
        r_ftw  <= Cfg_Ftw;
        r_wave <= wave_e'(Cfg_Wave);
      end else if (w_load_pend_act) begin
        r_ftw  <= r_pend_ftw;
        r_wave <= r_pend_wave;
      end
      if (w_load_pend) begin
        r_pend_ftw  <= Cfg_Ftw;
        r_pend_wave <= wave_e'(Cfg_Wave);
      end
      Phase_Wrap <= w_accum & w_carry;
    end
  end

  assign w_addr = r_phase[PHASE_W-2] ? ~r_phase[PHASE_W-3 -: LUT_AW]
                                     :  r_phase[PHASE_W-3 -: LUT_AW];

  fg_sine_lut #(
    .LUT_AW (LUT_AW),
    .DAC_W  (DAC_W)
  ) u_lut (
    .i_clk  (Fg_CLK),
    .i_rst  (Fg_RESET),
    .i_addr (w_addr),
    .o_data (w_lut)
  );

  always_comb begin
    w_shape = '0;
    case (r_wave)
      WAVE_SQUARE: w_shape = {DAC_W{~r_phase[PHASE_W-1]}};
      WAVE_SAW:    w_shape = r_phase[PHASE_W-1 -: DAC_W];
      WAVE_TRI:    w_shape = r_phase[PHASE_W-1] ? ~r_phase[PHASE_W-2 -: DAC_W]
                                                :  r_phase[PHASE_W-2 -: DAC_W];
      default:     w_shape = '0;
    endcase
  end

  always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
    if (Fg_RESET) begin
      r_shape1 <= '0;
      r_neg1   <= 1'b0;
      r_wave1  <= WAVE_SINE;
      r_live1  <= 1'b0;
    end else begin
      r_shape1 <= w_shape;
      r_neg1   <= r_phase[PHASE_W-1];
      r_wave1  <= r_wave;
      r_live1  <= (r_state != ST_IDLE);
    end
  end

  assign w_out_live = r_live1 & (r_state != ST_IDLE);

  always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
    if (Fg_RESET) begin
      Dac_Data  <= MID;
      Dac_Valid <= 1'b0;
    end else if (w_out_live) begin
      Dac_Valid <= 1'b1;
      if (r_wave1 == WAVE_SINE) Dac_Data <= r_neg1 ? (MID - {1'b0, w_lut}) : (MID + {1'b0, w_lut});
      else                      Dac_Data <= r_shape1;
    end else begin
      Dac_Data  <= MID;
      Dac_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fg_wave_gen.sv
// Scoreboard bench for fg_wave_gen: stimulus queues expected samples, a
// negedge monitor pops one per valid DAC sample; control outputs checked inline.
module tb_fg_wave_gen;
  import fg_pkg::*;

  logic        Fg_CLK;
  logic        Fg_RESET;
  logic        Run_En;
  logic        Cfg_Valid;
  logic        Cfg_Ready;
  logic [31:0] Cfg_Ftw;
  logic [1:0]  Cfg_Wave;
  logic [9:0]  Dac_Data;
  logic        Dac_Valid;
  logic        Phase_Wrap;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  fg_wave_gen #(
    .PHASE_W (32),
    .DAC_W   (10),
    .LUT_AW  (8)
  ) dut (
    .Fg_CLK     (Fg_CLK),
    .Fg_RESET   (Fg_RESET),
    .Run_En     (Run_En),
    .Cfg_Valid  (Cfg_Valid),
    .Cfg_Ready  (Cfg_Ready),
    .Cfg_Ftw    (Cfg_Ftw),
    .Cfg_Wave   (Cfg_Wave),
    .Dac_Data   (Dac_Data),
    .Dac_Valid  (Dac_Valid),
    .Phase_Wrap (Phase_Wrap)
  );

  initial Fg_CLK = 1'b0;
  always #5 Fg_CLK = ~Fg_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge Fg_CLK);
    #1;
  endtask

  task automatic check_park(input string name);
    check({name, "_data"}, 32'(Dac_Data), 32'h200);
    check({name, "_valid"}, 32'(Dac_Valid), 32'd0);
  endtask

  // Load a config in IDLE, run ncyc cycles, stop; phase steps a quarter turn per cycle.
  task automatic run_fixed(input logic [31:0] ftw, input logic [1:0] wave,
                           input logic [3:0][9:0] pat, input int unsigned ncyc,
                           input string name);
    Cfg_Valid = 1'b1; Cfg_Ftw = ftw; Cfg_Wave = wave;
    step(1);
    Cfg_Valid = 1'b0; Run_En = 1'b1;
    step(1);
    for (int unsigned c = 0; c < ncyc; c++) begin
      exp_q.push_back(pat[c % 4]);
      check({name, "_wrap"}, 32'(Phase_Wrap), 32'((c > 0) && (c % 4 == 0)));
      step(1);
    end
    Run_En = 1'b0;
    step(2);
    check_park({name, "_stop"});
  endtask

  always @(negedge Fg_CLK) begin
    if (Dac_Valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_sample: got 0x%0h with empty scoreboard at %0t", Dac_Data, $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("sample", 32'(Dac_Data), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Fg_RESET = 1'b1; Run_En = 1'b0; Cfg_Valid = 1'b0; Cfg_Ftw = '0; Cfg_Wave = 2'd0;
    repeat (3) @(posedge Fg_CLK);
    #1;
    Fg_RESET = 1'b0;
    step(1);
    check_park("reset");
    check("reset_ready", 32'(Cfg_Ready), 32'd1);
    check("reset_wrap", 32'(Phase_Wrap), 32'd0);

    // Saw at step 4 for two periods, then a reconfig to step 8 applied at the wrap.
    Cfg_Valid = 1'b1; Cfg_Ftw = 32'h0100_0000; Cfg_Wave = WAVE_SAW;
    step(1);
    Cfg_Valid = 1'b0; Run_En = 1'b1;
    step(1);
    for (int c = 0; c < 660; c++) begin
      logic [9:0] e;
      e = (c <= 512) ? 10'((c * 4) % 1024) : 10'(((c - 512) * 8) % 1024);
      exp_q.push_back(e);
      check("saw_wrap", 32'(Phase_Wrap), 32'((c == 256) || (c == 512) || (c == 640)));
      if (c == 1) check("valid_c1", 32'(Dac_Valid), 32'd0);
      if (c == 2) check("valid_c2", 32'(Dac_Valid), 32'd1);
      if (c == 300) begin
        check("ready_before_offer", 32'(Cfg_Ready), 32'd1);
        Cfg_Valid = 1'b1; Cfg_Ftw = 32'h0200_0000; Cfg_Wave = WAVE_SAW;
      end
      if (c == 301) begin
        check("ready_pend", 32'(Cfg_Ready), 32'd0);
        Cfg_Ftw = 32'h0800_0000; Cfg_Wave = WAVE_SQUARE;
      end
      if (c == 510) Cfg_Valid = 1'b0;
      if (c == 511) check("ready_pre_wrap", 32'(Cfg_Ready), 32'd0);
      if (c == 512) check("ready_post_wrap", 32'(Cfg_Ready), 32'd1);
      step(1);
    end
    Run_En = 1'b0;
    step(2);
    check_park("saw_stop");

    run_fixed(32'h4000_0000, WAVE_SQUARE, {10'h000, 10'h000, 10'h3FF, 10'h3FF}, 20, "square");
    run_fixed(32'h4000_0000, WAVE_SINE,   {10'h001, 10'h1FE, 10'h3FF, 10'h202}, 20, "sine");

    // Reset while a config is pending: it must be discarded along with the active one.
    Cfg_Valid = 1'b1; Cfg_Ftw = 32'h0100_0000; Cfg_Wave = WAVE_SAW;
    step(1);
    Cfg_Valid = 1'b0; Run_En = 1'b1;
    step(1);
    for (int c = 0; c < 8; c++) begin
      if (c <= 5) exp_q.push_back(10'(c * 4));
      if (c == 5) begin
        Cfg_Valid = 1'b1; Cfg_Ftw = 32'h0200_0000; Cfg_Wave = WAVE_SAW;
      end
      if (c == 6) begin
        Cfg_Valid = 1'b0;
        check("rst_pend_ready", 32'(Cfg_Ready), 32'd0);
      end
      step(1);
    end
    Run_En = 1'b0;
    Fg_RESET = 1'b1;
    #1;
    check_park("async_reset");
    check("async_reset_ready", 32'(Cfg_Ready), 32'd1);
    check("async_reset_wrap", 32'(Phase_Wrap), 32'd0);
    repeat (2) @(posedge Fg_CLK);
    #1;
    Fg_RESET = 1'b0;
    step(1);
    Run_En = 1'b1;
    step(1);
    // FTW is 0 (sine at phase 0); a config offered now applies one cycle after acceptance.
    for (int c = 0; c < 12; c++) begin
      logic [3:0][9:0] sq;
      sq = {10'h000, 10'h000, 10'h3FF, 10'h3FF};
      exp_q.push_back((c <= 4) ? 10'h202 : sq[(c - 5) % 4]);
      check("ftw0_wrap", 32'(Phase_Wrap), 32'(c == 9));
      if (c == 3) begin
        Cfg_Valid = 1'b1; Cfg_Ftw = 32'h4000_0000; Cfg_Wave = WAVE_SQUARE;
      end
      if (c == 4) begin
        Cfg_Valid = 1'b0;
        check("ftw0_ready_pend", 32'(Cfg_Ready), 32'd0);
      end
      if (c == 5) check("ftw0_ready_back", 32'(Cfg_Ready), 32'd1);
      step(1);
    end
    Run_En = 1'b0;
    step(2);
    check_park("final_stop");

    step(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
